// File: rtl/seq_p8_if.sv
// Sequencer bus: program ROM fetch, hold control, and the 12-bit device
// instruction dispatch port with status flags.
interface seq_p8_if;
   logic        hold;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic [11:0] inst;
   logic        inst_en;
   logic        halted;
   logic        error;

   modport master (
      input  hold, rom_data,
      output rom_addr, inst, inst_en, halted, error
   );

   modport slave (
      output hold, rom_data,
      input  rom_addr, inst, inst_en, halted, error
   );
endinterface

// File: rtl/seq_p8.sv
// 8-bit-PC instruction sequencer: runs jump/wait/loop/halt control ops and
// dispatches 12-bit device instructions. Optional macro: SEQ_P8_BADOP_TRAP_EN.
module seq_p8 (
   input  logic     clock,
   input  logic     reset,
   seq_p8_if.master bus
);

   typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_e;
   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_DSP = 4'h1, OP_JMP = 4'h2, OP_WAI = 4'h3,
      OP_LDC = 4'h4, OP_DJN = 4'h5, OP_HLT = 4'h6
   } op_e;

   state_e      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [7:0]  lc_q, lc_d;
   logic [7:0]  wc_q, wc_d;
   logic [11:0] inst_q, inst_d;
   logic        inst_en_q, inst_en_d;
   logic        halted_q, halted_d;
`ifdef SEQ_P8_BADOP_TRAP_EN
   logic        error_q, error_d;
`endif

   logic [3:0]  opcode;
   logic [7:0]  imm;
   logic [7:0]  pc_inc;
   logic [7:0]  lc_dec;

   assign opcode = bus.rom_data[15:12];
   assign imm    = bus.rom_data[7:0];
   assign pc_inc = pc_q + 8'd1;
   assign lc_dec = lc_q - 8'd1;

   always_comb begin
      // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      pc_d      = pc_q;
      lc_d      = lc_q;
      wc_d      = wc_q;
      inst_d    = inst_q;
      inst_en_d = 1'b0;
      halted_d  = halted_q;
`ifdef SEQ_P8_BADOP_TRAP_EN
      error_d   = error_q;
`endif
      if (!bus.hold) begin
         unique case (state_q)
            ST_RUN: begin
               case (opcode)
                  OP_NOP: pc_d = pc_inc;
                  OP_DSP: begin
                     inst_d    = bus.rom_data[11:0];
                     inst_en_d = 1'b1;
                     pc_d      = pc_inc;
                  end
                  OP_JMP: pc_d = imm;
                  OP_WAI: begin
                     if (imm != 8'd0) begin
                        wc_d    = imm;
                        state_d = ST_WAIT;
                     end
                     pc_d = pc_inc;
                  end
                  OP_LDC: begin
                     lc_d = imm;
                     pc_d = pc_inc;
                  end
                  OP_DJN: begin
                     lc_d = lc_dec;
                     pc_d = (lc_dec != 8'd0) ? imm : pc_inc;
                  end
                  OP_HLT: begin
                     state_d  = ST_HALT;
                     halted_d = 1'b1;
                  end
                  default: begin
`ifdef SEQ_P8_BADOP_TRAP_EN
                     state_d  = ST_HALT;
                     halted_d = 1'b1;
                     error_d  = 1'b1;
`else
                     pc_d = pc_inc;
`endif
                  end
               endcase
            end
            ST_WAIT: begin
               // Leave on the cycle the counter lands on zero: WAI n spends n cycles here.
               wc_d = wc_q - 8'd1;
               if (wc_q == 8'd1) state_d = ST_RUN;
            end
            ST_HALT: ;
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_RUN;
         pc_q      <= 8'h00;
         lc_q      <= 8'h00;
         wc_q      <= 8'h00;
         inst_q    <= 12'h000;
         inst_en_q <= 1'b0;
         halted_q  <= 1'b0;
`ifdef SEQ_P8_BADOP_TRAP_EN
         error_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q   <= state_d;
         pc_q      <= pc_d;
         lc_q      <= lc_d;
         wc_q      <= wc_d;
         inst_q    <= inst_d;
         inst_en_q <= inst_en_d;
         halted_q  <= halted_d;
`ifdef SEQ_P8_BADOP_TRAP_EN
         error_q   <= error_d;
`endif
      end
   end

   assign bus.rom_addr = pc_q;
   assign bus.inst     = inst_q;
   assign bus.inst_en  = inst_en_q;
   assign bus.halted   = halted_q;
`ifdef SEQ_P8_BADOP_TRAP_EN
   assign bus.error    = error_q;
`else
   assign bus.error    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_p8.sv
// Directed bench for seq_p8: each program is traced by hand, outputs are
// sampled 1 ns after the rising edge.
module tb_seq_p8;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] rom [256];
   int          checks = 0;
   int          errors = 0;

   seq_p8_if bus ();

   assign bus.rom_data = rom[bus.rom_addr];

   seq_p8 dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'h6000;
   endtask

   // Reset through one edge and release; the next edge executes rom[0].
   task automatic run_from_reset();
      reset    = 1'b0;
      bus.hold = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      int         cnt;
      logic [11:0] seen [$];

      bus.hold = 1'b0;
      clear_rom();
      #2;
      check("rst_addr",    bus.rom_addr, 8'h00);
      check("rst_inst",    bus.inst,     12'h000);
      check("rst_inst_en", bus.inst_en,  1'b0);
      check("rst_halted",  bus.halted,   1'b0);
      check("rst_error",   bus.error,    1'b0);

      // Back-to-back dispatch then halt.
      clear_rom();
      rom[0] = 16'h10BA; rom[1] = 16'h11FE; rom[2] = 16'h6000;
      run_from_reset();
      tick();
      check("dsp1_en",   bus.inst_en, 1'b1);
      check("dsp1_inst", bus.inst,    12'h0BA);
      tick();
      check("dsp2_en",   bus.inst_en, 1'b1);
      check("dsp2_inst", bus.inst,    12'h1FE);
      tick();
      check("hlt_halted", bus.halted,   1'b1);
      check("hlt_pc",     bus.rom_addr, 8'h02);
      check("hlt_en",     bus.inst_en,  1'b0);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.inst_en) cnt++;
      end
      check("hlt_no_dispatch", cnt,          0);
      check("hlt_pc_frozen",   bus.rom_addr, 8'h02);
      check("hlt_inst_frozen", bus.inst,     12'h1FE);

      // Counted loop: three passes.
      clear_rom();
      rom[0] = 16'h4003; rom[1] = 16'h1123; rom[2] = 16'h5001; rom[3] = 16'h6000;
      run_from_reset();
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.inst_en) begin
            cnt++;
            check("loop_inst", bus.inst, 12'h123);
         end
      end
      check("loop_count",  cnt,          3);
      check("loop_halted", bus.halted,   1'b1);
      check("loop_pc",     bus.rom_addr, 8'h03);
      check("loop_lc",     dut.lc_q,     8'h00);

      // WAI 4: dispatch visible after the sixth edge.
      clear_rom();
      rom[0] = 16'h3004; rom[1] = 16'h1043; rom[2] = 16'h6000;
      run_from_reset();
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.inst_en) cnt++;
      end
      check("wai_quiet", cnt, 0);
      tick();
      check("wai_en",   bus.inst_en, 1'b1);
      check("wai_inst", bus.inst,    12'h043);

      // Hold for three cycles in a DSP stream.
      clear_rom();
      for (int i = 0; i < 5; i++) rom[i] = 16'h1000 | 16'(i + 1);
      rom[5] = 16'h6000;
      run_from_reset();
      seen.delete();
      for (int i = 0; i < 2; i++) begin
         tick();
         if (bus.inst_en) seen.push_back(bus.inst);
      end
      bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_en", bus.inst_en,  1'b0);
         check("hold_pc", bus.rom_addr, 8'h02);
      end
      bus.hold = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.inst_en) seen.push_back(bus.inst);
      end
      check("hold_count", seen.size(), 5);
      for (int i = 0; i < seen.size(); i++) check("hold_order", seen[i], 12'(i + 1));
      check("hold_halted", bus.halted, 1'b1);

      // Bad opcode at 0x01.
      clear_rom();
      rom[0] = 16'h0000; rom[1] = 16'hF0AB; rom[2] = 16'h1077; rom[3] = 16'h6000;
      run_from_reset();
      tick();
      tick();
`ifdef SEQ_P8_BADOP_TRAP_EN
      check("trap_halted", bus.halted,   1'b1);
      check("trap_error",  bus.error,    1'b1);
      check("trap_pc",     bus.rom_addr, 8'h01);
      tick();
      check("trap_pc_hold", bus.rom_addr, 8'h01);
      check("trap_no_en",   bus.inst_en,  1'b0);
`else
      check("badop_pc",     bus.rom_addr, 8'h02);
      check("badop_halted", bus.halted,   1'b0);
      tick();
      check("badop_en",    bus.inst_en, 1'b1);
      check("badop_inst",  bus.inst,    12'h077);
      check("badop_error", bus.error,   1'b0);
`endif

      // Reset mid-dispatch and mid-wait.
      clear_rom();
      rom[0] = 16'h1055; rom[1] = 16'h3010;
      run_from_reset();
      tick();
      check("mid_dsp_en", bus.inst_en, 1'b1);
      reset = 1'b0;
      #1;
      check("mid_dsp_rst_en",   bus.inst_en,  1'b0);
      check("mid_dsp_rst_inst", bus.inst,     12'h000);
      check("mid_dsp_rst_pc",   bus.rom_addr, 8'h00);
      reset = 1'b1;
      tick();
      tick();
      tick();
      tick();
      check("mid_wait_wc", dut.wc_q,     8'h0E);
      check("mid_wait_pc", bus.rom_addr, 8'h02);
      reset = 1'b0;
      #1;
      check("mid_wait_rst_pc", bus.rom_addr, 8'h00);
      check("mid_wait_rst_wc", dut.wc_q,     8'h00);
      check("mid_wait_rst_en", bus.inst_en,  1'b0);
      reset = 1'b1;
      tick();
      check("restart_pc",   bus.rom_addr, 8'h01);
      check("restart_inst", bus.inst,     12'h055);

      // PC wrap: JMP 0xFF, NOP at 0xFF rolls over to 0x00.
      clear_rom();
      rom[0] = 16'h20FF; rom[255] = 16'h0000;
      run_from_reset();
      tick();
      check("wrap_jmp", bus.rom_addr, 8'hFF);
      tick();
      check("wrap_pc",  bus.rom_addr, 8'h00);
      tick();
      check("wrap_again", bus.rom_addr, 8'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_p8.md
Name: seq_p8

Overview:
- Upstream instruction sequencer for the 8-register bank and sibling 12-bit-instruction peripherals.
- Steps a program counter through an external combinational program ROM of 16-bit words, executes its own control opcodes (jump, wait, loop, halt) and dispatches 12-bit device instructions on inst/inst_en, one per cycle.
- Output port pair connects directly to the register bank's inst/inst_en inputs.

Parameters:
- none (widths fixed: 8-bit PC, 16-bit ROM word, 12-bit dispatched instruction)

Ports:
- clock      in   1   system clock, rising edge
- reset      in   1   asynchronous, active-low reset
- hold       in   1   1 = freeze sequencer (PC, counters, state unchanged)
- rom_addr   out  8   program ROM address, equals PC
- rom_data   in   16  ROM word at rom_addr, valid same cycle: [15:12] seq opcode, [11:0] payload
- inst       out  12  dispatched device instruction {opcode[11:8], imm[7:0]}
- inst_en    out  1   1 = inst valid this cycle
- halted     out  1   1 = HLT executed
- error      out  1   bad-opcode trap flag (see Optional Feature; else constant 0)

Behaviour:
- Reset (reset=0, async): pc=0x00, loop counter lc=0x00, wait counter wc=0x00, state=RUN, inst=12'h000, inst_en=0, halted=0, error=0.
- States: RUN, WAIT, HALT. All outputs registered; rom_addr = pc.
- Seq opcodes [15:12], imm = rom_data[7:0]:
  - 0 NOP: pc+1.
  - 1 DSP: next cycle inst=rom_data[11:0], inst_en=1; pc+1.
  - 2 JMP: pc=imm.
  - 3 WAI: imm=0 acts as NOP. Else wc=imm, state=WAIT, pc+1.
  - 4 LDC: lc=imm; pc+1.
  - 5 DJN: lc=lc-1 (8-bit wrap). If lc-1 != 0, pc=imm; else pc+1. lc=0 at DJN wraps to 0xFF and jumps.
  - 6 HLT: state=HALT, halted=1, pc unchanged.
  - 7..F: treated as NOP unless trap enabled.
- inst_en=1 only in the cycle after a DSP executes in RUN with hold=0; 0 in every other cycle. inst holds its last dispatched value when inst_en=0.
- Latency: DSP at pc in cycle N gives inst/inst_en valid in cycle N+1. Back-to-back DSPs give inst_en=1 continuously, one instruction per cycle.
- WAIT: wc decrements each non-held cycle. Return to RUN on the cycle wc reaches 0, so WAI imm costs imm+1 cycles total. No instruction executes while in WAIT.
- HALT: only reset exits. pc, lc and inst are frozen; inst_en=0.
- pc increment wraps 0xFF to 0x00.
- hold=1: no state or counter change, inst_en=0 next cycle. An instruction presented under hold executes once hold drops. hold has no effect in HALT.
- Reset asserted mid-WAIT or mid-dispatch: immediate return to reset values, with inst_en=0 that cycle.

Optional Feature:
- Macro SEQ_P8_BADOP_TRAP_EN.
- Defined: opcodes 7..F enter HALT and set halted=1 and error=1; pc stays at the faulting address.
- Undefined: opcodes 7..F act as NOP and error is tied to 0.

Test Plan:
- Reset, then ROM {0x10BA, 0x11FE, 0x6000} → inst_en=1 for 2 cycles with inst=0x0BA then 0x1FE; then halted=1, pc=0x02, inst_en=0 thereafter.
- ROM {0x4003, 0x1123, 0x5001, 0x6000} → 0x123 dispatched exactly 3 times, one per loop pass; lc=0 at HLT.
- ROM {0x3004, 0x1043, 0x6000} → inst_en rises exactly 6 cycles after leaving reset (1 for WAI, 4 wait, 1 for DSP latency); inst=0x043.
- Stream of DSPs with hold=1 for 3 cycles mid-program → inst_en=0 for those cycles; no instruction dropped or duplicated; pc resumes at the same value.
- ROM word 0xF0AB at 0x01 → with SEQ_P8_BADOP_TRAP_EN: halted=1, error=1, pc=0x01. Without it: treated as NOP, execution continues at 0x02, error=0.
- Drop reset during WAIT (wc=0x10) → outputs return to reset values immediately; after release, execution restarts from pc=0x00; JMP 0xFF followed by NOP at 0xFF wraps pc to 0x00.
